// File: rtl/ula_pkg.sv
// Shared ULA operation codes and multiply-controller state encoding.
// Used by the multiply sequencer and the main ULA control block.
package ula_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABS_A  = 3'd1,
        ST_ABS_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_NEG_LO = 3'd4,
        ST_NOT_HI = 3'd5,
        ST_INC_HI = 3'd6,
        ST_DONE   = 3'd7
    } mult_state_e;

endpackage

// File: rtl/ula_mult_ctrl.sv
// Shift-and-add 32x32 multiplier sequencer that borrows the shared ULA.
// Signed operands are made positive first and the product negated last.
module ula_mult_ctrl
    import ula_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] alu_result,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mult_state_e state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] mcand_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        signed_q;
    logic        sign_q;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  cnt_q;
    logic        carry;

    // ULA request for the current state; idle states present ADD(0,0)
    always_comb begin
        alu_in1 = '0;
        alu_in2 = '0;
        alu_op  = ALU_ADD;
        unique case (state_q)
            ST_ABS_A: begin
                if (a_q[31]) begin
                    alu_op  = ALU_SUB;
                    alu_in2 = a_q;
                end else begin
                    alu_in1 = a_q;
                end
            end
            ST_ABS_B: begin
                if (b_q[31]) begin
                    alu_op  = ALU_SUB;
                    alu_in2 = b_q;
                end else begin
                    alu_in1 = b_q;
                end
            end
            ST_ITER: begin
                alu_in1 = hi_q;
                alu_in2 = lo_q[0] ? mcand_q : '0;
            end
            ST_NEG_LO: begin
                if (sign_q) begin
                    alu_op  = ALU_SUB;
                    alu_in2 = lo_q;
                end else begin
                    alu_in1 = lo_q;
                end
            end
            ST_NOT_HI: begin
                alu_in1 = hi_q;
                if (sign_q) alu_op = ALU_NOR;
            end
            ST_INC_HI: begin
                alu_in1 = hi_q;
                if (sign_q) alu_in2 = {31'b0, (lo_q == 32'd0)};
            end
            default: ;
        endcase
    end

    // Carry out of the partial-product add, recovered from the ULA sum
    assign carry = (alu_result < hi_q);

    // Sequencer state, operand latches and product registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            signed_q <= 1'b0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        signed_q <= is_signed;
                        sign_q   <= op_a[31] ^ op_b[31];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (is_signed) begin
                            state_q <= ST_ABS_A;
                        end else begin
                            hi_q    <= '0;
                            lo_q    <= op_b;
                            mcand_q <= op_a;
                            state_q <= ST_ITER;
                        end
                    end
                end
                ST_ABS_A: begin
                    mcand_q <= alu_result;
                    state_q <= ST_ABS_B;
                end
                ST_ABS_B: begin
                    lo_q    <= alu_result;
                    hi_q    <= '0;
                    state_q <= ST_ITER;
                end
                ST_ITER: begin
                    hi_q  <= {carry, alu_result[31:1]};
                    lo_q  <= {alu_result[0], lo_q[31:1]};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        if (signed_q) begin
                            state_q <= ST_NEG_LO;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_NEG_LO: begin
                    lo_q    <= alu_result;
                    state_q <= ST_NOT_HI;
                end
                ST_NOT_HI: begin
                    hi_q    <= alu_result;
                    state_q <= ST_INC_HI;
                end
                ST_INC_HI: begin
                    hi_q    <= alu_result;
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
